// File: rtl/mmio_if.sv
// CPU-side MMIO bus bundle for the I/O responder.
// The master drives strobes, the slave returns decode and read data.
interface mmio_if #(
  parameter int WIDTH    = 16,
  parameter int ADDRBITS = 10
) ();
  logic [ADDRBITS-1:0] addr;
  logic [WIDTH-1:0]    wdata;
  logic                we;
  logic                re;
  logic                io_sel;
  logic [WIDTH-1:0]    rdata;
  logic                rvalid;

  modport master (
    output addr, wdata, we, re,
    input  io_sel, rdata, rvalid
  );

  modport slave (
    input  addr, wdata, we, re,
    output io_sel, rdata, rvalid
  );
endinterface

// File: rtl/mmio_responder.sv
// Memory-mapped I/O block: LED, debounced switches, status/irq
// and a free-running tick counter behind a 1-cycle read port.
module mmio_responder #(
  parameter int WIDTH    = 16,
  parameter int ADDRBITS = 10,
  parameter int DEBOUNCE = 16
) (
  input  logic       clk,
  input  logic       reset,
  mmio_if.slave      bus,
  input  logic [9:0] switches,
  output logic [9:0] LEDs,
  output logic       irq
);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [9:0]       sync1_q, sync2_q;
  logic [9:0]       deb_q, deb_d;
  logic [9:0]       led_q, led_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             chg_q, chg_d;
  logic             ie_q, ie_d;
  logic             rvalid_q, rvalid_d;
  logic [15:0]      tick_q, tick_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] rsel;
  logic [1:0]       ra;
  logic             acc_rd, acc_wr, upd;
  logic             unused_addr;

  assign unused_addr = ^bus.addr[7:2];
  assign bus.io_sel  = (bus.addr[9:8] == 2'b11);
  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;
  assign LEDs        = led_q;
  assign irq         = chg_q & ie_q;

  always_comb begin
    ra     = bus.addr[1:0];
    acc_rd = bus.re && bus.io_sel;
    acc_wr = bus.we && bus.io_sel;

    unique case (ra)
      2'd0:    rsel = WIDTH'(led_q);
      2'd1:    rsel = WIDTH'(deb_q);
      2'd2:    rsel = WIDTH'({ie_q, chg_q});
      default: rsel = WIDTH'(tick_q);
    endcase

    // counter only advances while the synced vector differs and is steady
    upd   = 1'b0;
    cnt_d = '0;
    deb_d = deb_q;
    if ((sync2_q != deb_q) && (sync1_q == sync2_q)) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        upd   = 1'b1;
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    led_d  = led_q;
    ie_d   = ie_q;
    chg_d  = chg_q;
    tick_d = tick_q + 16'd1;
    if (acc_wr) begin
      unique case (ra)
        2'd0: led_d = bus.wdata[9:0];
        2'd2: begin
          ie_d = bus.wdata[1];
          if (bus.wdata[0]) chg_d = 1'b0;
        end
        2'd3: tick_d = 16'(bus.wdata);
        default: ;
      endcase
    end
    if (acc_rd && (ra == 2'd2)) chg_d = 1'b0;
    if (upd) chg_d = 1'b1;

    rvalid_d = acc_rd;
    rdata_d  = acc_rd ? rsel : rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      cnt_q    <= '0;
      led_q    <= '0;
      chg_q    <= 1'b0;
      ie_q     <= 1'b0;
      tick_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      sync1_q  <= switches;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      chg_q    <= chg_d;
      ie_q     <= ie_d;
      tick_q   <= tick_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed scenarios plus random traffic
// checked against a window-based behavioural model.
module tb_mmio_responder;
  localparam int W  = 16;
  localparam int AB = 10;
  localparam int D  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] switches;
  logic [9:0] LEDs;
  logic       irq;

  mmio_if #(.WIDTH(W), .ADDRBITS(AB)) bus ();

  mmio_responder #(.WIDTH(W), .ADDRBITS(AB), .DEBOUNCE(D)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .switches(switches), .LEDs(LEDs), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [9:0]   m_led, m_deb;
  logic         m_ie, m_chg, m_rv;
  logic [15:0]  m_tick;
  logic [W-1:0] m_rd;
  logic [9:0]   hist[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_led = '0; m_deb = '0; m_ie = 1'b0; m_chg = 1'b0;
    m_rv = 1'b0; m_tick = '0; m_rd = '0;
    hist.delete();
    for (int i = 0; i < D + 1; i++) hist.push_back('0);
  endfunction

  // switches accepted once D+1 consecutive raw samples agree
  function automatic void m_edge();
    logic io, stable;
    logic [1:0] ra;
    logic [W-1:0] v;
    io = (bus.addr[9:8] == 2'b11);
    ra = bus.addr[1:0];
    case (ra)
      2'd0:    v = W'(m_led);
      2'd1:    v = W'(m_deb);
      2'd2:    v = W'({m_ie, m_chg});
      default: v = W'(m_tick);
    endcase
    stable = 1'b1;
    foreach (hist[i]) if (hist[i] != hist[0]) stable = 1'b0;
    m_rv = io && bus.re;
    if (m_rv) m_rd = v;
    if (m_rv && ra == 2'd2) m_chg = 1'b0;
    m_tick = m_tick + 16'd1;
    if (io && bus.we) begin
      case (ra)
        2'd0: m_led = bus.wdata[9:0];
        2'd2: begin
          m_ie = bus.wdata[1];
          if (bus.wdata[0]) m_chg = 1'b0;
        end
        2'd3: m_tick = bus.wdata[15:0];
        default: ;
      endcase
    end
    if (stable && hist[0] != m_deb) begin
      m_deb = hist[0];
      m_chg = 1'b1;
    end
    void'(hist.pop_front());
    hist.push_back(switches);
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset) m_edge();
    #1;
    chk("rvalid", bus.rvalid, m_rv);
    chk("rdata", bus.rdata, m_rd);
    chk("LEDs", LEDs, m_led);
    chk("irq", irq, m_chg & m_ie);
  endtask

  task automatic setbus(input logic [9:0] a, input logic [15:0] d,
                        input logic w, input logic r);
    bus.addr = a; bus.wdata = d; bus.we = w; bus.re = r;
  endtask

  task automatic idle();
    setbus(10'h000, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] d);
    setbus(a, d, 1'b1, 1'b0);
    step();
    idle();
  endtask

  task automatic rd(input logic [9:0] a);
    setbus(a, 16'h0000, 1'b0, 1'b1);
    step();
    idle();
  endtask

  initial begin
    reset = 1'b0;
    switches = '0;
    idle();
    m_reset();
    #2;
    chk("rst_leds", LEDs, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_irq", irq, 0);
    step();
    step();
    reset = 1'b1;

    bus.addr = 10'h2FF; #1;
    chk("iosel_lo", bus.io_sel, 0);
    bus.addr = 10'h3AB; #1;
    chk("iosel_hi", bus.io_sel, 1);
    idle();

    wr(10'h300, 16'h03FF);
    chk("led_wr", LEDs, 10'h3FF);
    rd(10'h300);
    chk("led_rd_valid", bus.rvalid, 1);
    chk("led_rd", bus.rdata, 16'h03FF);
    step();
    chk("rvalid_pulse", bus.rvalid, 0);
    chk("rdata_hold", bus.rdata, 16'h03FF);
    rd(10'h3FC);
    chk("alias_rd", bus.rdata, 16'h03FF);

    wr(10'h302, 16'h0002);
    switches = 10'h155;
    repeat (D + 1) step();
    chk("irq_early", irq, 0);
    step();
    chk("irq_set", irq, 1);
    rd(10'h301);
    chk("sw_rd", bus.rdata, 16'h0155);

    rd(10'h302);
    chk("status_rd", bus.rdata, 16'h0003);
    chk("irq_clr_rd", irq, 0);
    switches = 10'h0AA;
    repeat (D + 1) step();
    rd(10'h302);
    chk("status_rd2", bus.rdata, 16'h0002);
    chk("set_wins", irq, 1);
    rd(10'h301);
    chk("sw_rd2", bus.rdata, 16'h00AA);
    wr(10'h302, 16'h0003);
    chk("chg_wclr", irq, 0);

    for (int k = 0; k < 12; k++) begin
      switches = k[0] ? 10'h000 : 10'h155;
      repeat (5) begin
        step();
        chk("irq_toggle", irq, 0);
      end
    end
    switches = 10'h0AA;
    repeat (4) step();
    rd(10'h301);
    chk("sw_toggle", bus.rdata, 16'h00AA);
    rd(10'h302);
    chk("status_toggle", bus.rdata, 16'h0002);

    wr(10'h303, 16'hFFFE);
    step();
    step();
    rd(10'h303);
    chk("tick_wrap", bus.rdata, 16'h0000);
    setbus(10'h200, 16'h0155, 1'b1, 1'b1);
    step();
    idle();
    chk("nosel_rvalid", bus.rvalid, 0);
    chk("nosel_leds", LEDs, 10'h3FF);
    chk("nosel_rdata", bus.rdata, 16'h0000);
    wr(10'h301, 16'h03FF);
    rd(10'h301);
    chk("sw_ro", bus.rdata, 16'h00AA);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        bus.addr = 10'($urandom_range(0, 1023));
      else
        bus.addr = {2'b11, 8'($urandom_range(0, 255))};
      bus.wdata = 16'($urandom_range(0, 65535));
      bus.we = ($urandom_range(0, 3) == 0);
      bus.re = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 39) == 0)
        switches = 10'($urandom_range(0, 1023));
      step();
    end
    idle();

    switches = 10'h3C3;
    repeat (6) step();
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    chk("arst_leds", LEDs, 0);
    chk("arst_rdata", bus.rdata, 0);
    chk("arst_rvalid", bus.rvalid, 0);
    chk("arst_irq", irq, 0);
    step();
    step();
    reset = 1'b1;
    rd(10'h303);
    chk("tick_first", bus.rdata, 16'h0000);
    rd(10'h303);
    chk("tick_second", bus.rdata, 16'h0001);
    wr(10'h302, 16'h0002);
    repeat (D - 2) begin
      step();
      chk("irq_post_rst", irq, 0);
    end
    step();
    chk("irq_rederive", irq, 1);
    rd(10'h301);
    chk("sw_rederive", bus.rdata, 16'h03C3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_responder.md
MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 Parameter WIDTH, default 16, data-bus width.
REQ-002 Parameter ADDRBITS, default 10, address-bus width.
REQ-003 Parameter DEBOUNCE, default 16, cycles a synchronized switch vector must hold stable before acceptance.
REQ-004 Design SHALL use one clock; reset SHALL be asynchronous, active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 addr  input  ADDRBITS  CPU address.
REQ-008 wdata  input  WIDTH  CPU write data.
REQ-009 we  input  1  write strobe.
REQ-010 re  input  1  read strobe.
REQ-011 switches  input  10  raw asynchronous board switches.
REQ-012 io_sel  output  1  combinational decode, high when addr[9:8]==2'b11.
REQ-013 rdata  output  WIDTH  registered read data.
REQ-014 rvalid  output  1  one-cycle read-data-valid pulse.
REQ-015 LEDs  output  10  LED register.
REQ-016 irq  output  1  switch-change interrupt.

Function
REQ-017 Register map by addr[1:0] when io_sel: 0 LED (RW), 1 SW (RO), 2 STATUS, 3 TICK (RW); addr[7:2] ignored (aliases).
REQ-018 Access SHALL occur only when io_sel=1; strobes with io_sel=0 have no effect and produce no rvalid.
REQ-019 Write to LED SHALL load wdata[9:0] into LEDs at the clock edge.
REQ-020 Writes to SW SHALL be ignored.
REQ-021 STATUS: bit0 CHG (sticky), bit1 IE, bits[15:2] read 0.
REQ-022 Write to STATUS SHALL load IE from wdata[1] and clear CHG when wdata[0]=1.
REQ-023 TICK SHALL be a 16-bit free-running counter incrementing every cycle, wrapping 0xFFFF->0x0000; a write loads wdata, increment resumes next cycle.
REQ-024 Read: re with io_sel at edge N SHALL drive rdata with the selected register's value before edge N and rvalid=1 for the cycle after edge N (latency 1).
REQ-025 rdata SHALL hold its last value while rvalid=0.
REQ-026 SW reads SHALL return debounced value zero-extended to WIDTH.
REQ-027 Reading STATUS SHALL clear CHG at the same edge, unless a new change event occurs on that edge, in which case CHG stays 1 (set wins).
REQ-028 we and re together to the same register: read returns pre-write value; write takes effect.
REQ-029 switches SHALL pass a two-flop synchronizer before use.
REQ-030 Debounce: one shared counter; counts while synchronized vector differs from debounced vector, clears to 0 when equal or when synchronized vector changes mid-count.
REQ-031 When the counter reaches DEBOUNCE-1 with vector still different, debounced value SHALL update, counter clears, CHG sets, on that edge.
REQ-032 irq SHALL equal CHG AND IE, combinational from registers.

Reset
REQ-033 On reset low, immediately: LEDs=0, rdata=0, rvalid=0, IE=0, CHG=0, TICK=0, debounce counter=0, synchronizer and debounced vector=0.
REQ-034 Reset asserted mid-debounce SHALL discard the pending change; after release the debounced value re-derives from switches per REQ-030/031 (CHG sets if switches nonzero).
REQ-035 First increment of TICK SHALL occur on the first rising edge after reset release.

Verification
REQ-036 Write 0x03FF to addr 0x300 -> LEDs=0x3FF next cycle; read 0x300 -> rdata=0x03FF with rvalid one cycle after strobe.
REQ-037 switches=0x155 held stable -> SW reads 0x0155 and CHG=1 exactly 2+DEBOUNCE cycles after change; IE=1 gives irq=1.
REQ-038 switches toggle 0x155/0x000 every 5 cycles with DEBOUNCE=16 -> debounced value and CHG never change.
REQ-039 Read STATUS (addr 0x302) with CHG=1 -> rdata=0x0003 (IE=1), CHG=0 and irq=0 after edge; repeat with debounce completing on the read edge -> CHG remains 1.
REQ-040 Write 0xFFFE to addr 0x303, idle 2 cycles, read -> 0x0000 returned (wrap); strobe to 0x200 -> no rvalid, no register change.
REQ-041 Assert reset during active TICK count and pending debounce -> all outputs 0 asynchronously, no CHG after release until a full DEBOUNCE window elapses.
